// File: rtl/video_pattern_gen_pkg.sv
// Shared definitions for the video pattern generator: FSM encoding,
// pattern codes, register addresses and colour-bar palette.
package video_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_SOLID    = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_t;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_COLOR   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // RGB565 bar colours, left to right
  localparam logic [15:0] BAR_COLOR_0 = 16'hFFFF;  // white
  localparam logic [15:0] BAR_COLOR_1 = 16'hFFE0;  // yellow
  localparam logic [15:0] BAR_COLOR_2 = 16'h07FF;  // cyan
  localparam logic [15:0] BAR_COLOR_3 = 16'h07E0;  // green
  localparam logic [15:0] BAR_COLOR_4 = 16'hF81F;  // magenta
  localparam logic [15:0] BAR_COLOR_5 = 16'hF800;  // red
  localparam logic [15:0] BAR_COLOR_6 = 16'h001F;  // blue
  localparam logic [15:0] BAR_COLOR_7 = 16'h0000;  // black

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_COLOR_0;
      3'd1:    return BAR_COLOR_1;
      3'd2:    return BAR_COLOR_2;
      3'd3:    return BAR_COLOR_3;
      3'd4:    return BAR_COLOR_4;
      3'd5:    return BAR_COLOR_5;
      3'd6:    return BAR_COLOR_6;
      default: return BAR_COLOR_7;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen_pattern_pixel_calc.sv
// Combinational pixel colour for the current raster position.
// Only the low byte of each coordinate matters to any pattern.
module pattern_pixel_calc
  import video_pattern_gen_pkg::*;
(
  input  logic [1:0]  pattern,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  bar_idx,
  input  logic [15:0] color,
  output logic [15:0] pixel
);

  logic unused_coord_bits;
  assign unused_coord_bits = ^{x[2:0], y[1:0]};

  // Select the colour of the requested pattern
  always_comb begin
    pixel = 16'h0000;
    case (pattern_t'(pattern))
      PAT_SOLID:    pixel = color;
      PAT_BARS:     pixel = bar_color(bar_idx);
      PAT_GRADIENT: pixel = {x[7:3], y[7:2], ~x[7:3]};
      PAT_CHECKER:  pixel = (x[4] ^ y[4]) ? color : 16'h0000;
      default:      pixel = 16'h0000;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Avalon-MM configured test pattern source streaming RGB565 frames
// over Avalon-ST (ready latency 0).
//
// state     | meaning
// ST_IDLE   | waiting for enable, no output
// ST_STREAM | emitting pixels of one frame in raster order
// ST_DONE   | one-cycle gap after the last pixel, decides next frame
module video_pattern_gen
  import video_pattern_gen_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        source_valid_out,
  input  logic        source_ready_in,
  output logic [15:0] source_data_out,
  output logic        source_startofpacket_out,
  output logic        source_endofpacket_out
);

  localparam int XW      = $clog2(WIDTH);
  localparam int YW      = $clog2(HEIGHT);
  localparam int BAR_LEN = WIDTH / 8;
  localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

  state_t      state_q, state_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [BW-1:0] bar_cnt_q;
  logic [2:0]    bar_idx_q;

  logic        enable_q, single_shot_q;
  logic [1:0]  pattern_sel_q;
  logic [15:0] solid_color_q;
  logic [1:0]  pattern_lat_q;
  logic [15:0] color_lat_q;
  logic [15:0] frame_count_q;
  logic [31:0] readdata_q;
  logic [31:0] rd_mux;

  logic        busy;
  logic        xfer, last_x, last_y, last_bar_px, eop_xfer, start_frame;
  logic        mm_write;
  logic [15:0] pixel;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  assign mm_write    = chipselect & write;
  assign xfer        = source_valid_out & source_ready_in;
  assign last_x      = (x_q == XW'(WIDTH - 1));
  assign last_y      = (y_q == YW'(HEIGHT - 1));
  assign last_bar_px = (bar_cnt_q == BW'(BAR_LEN - 1));
  assign eop_xfer    = xfer & last_x & last_y;
  assign start_frame = (state_q != ST_STREAM) && (state_d == ST_STREAM);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enable_q) state_d = ST_STREAM;
      ST_STREAM: if (eop_xfer) state_d = ST_DONE;
      ST_DONE: begin
        if (single_shot_q)  state_d = ST_IDLE;
        else if (enable_q)  state_d = ST_STREAM;
        else                state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; pixel fields derive from held counters so they stay stable under backpressure
  always_comb begin
    source_valid_out         = (state_q == ST_STREAM);
    busy                     = (state_q != ST_IDLE);
    source_startofpacket_out = source_valid_out && (x_q == '0) && (y_q == '0);
    source_endofpacket_out   = source_valid_out && last_x && last_y;
    source_data_out          = source_valid_out ? pixel : 16'h0000;
  end

  // Raster and bar counters plus per-frame configuration snapshot
  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      pattern_lat_q <= '0;
      color_lat_q   <= '0;
    end else if (start_frame) begin
      x_q           <= '0;
      y_q           <= '0;
      bar_cnt_q     <= '0;
      bar_idx_q     <= '0;
      pattern_lat_q <= pattern_sel_q;
      color_lat_q   <= solid_color_q;
    end else if (xfer) begin
      if (last_x) begin
        x_q       <= '0;
        bar_cnt_q <= '0;
        bar_idx_q <= '0;
        y_q       <= last_y ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
        if (last_bar_px) begin
          bar_cnt_q <= '0;
          bar_idx_q <= bar_idx_q + 1'b1;
        end else begin
          bar_cnt_q <= bar_cnt_q + 1'b1;
        end
      end
    end
  end

  // Writable control registers; a finished single-shot frame disarms the control register
  always_ff @(posedge clk) begin
    if (!reset) begin
      enable_q      <= 1'b0;
      single_shot_q <= 1'b0;
      pattern_sel_q <= '0;
      solid_color_q <= '0;
    end else begin
      if (state_q == ST_DONE && single_shot_q) begin
        enable_q      <= 1'b0;
        single_shot_q <= 1'b0;
      end
      if (mm_write) begin
        case (address)
          ADDR_CTRL: begin
            enable_q      <= writedata[0];
            single_shot_q <= writedata[1];
          end
          ADDR_PATTERN: pattern_sel_q <= writedata[1:0];
          ADDR_COLOR:   solid_color_q <= writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!reset)        frame_count_q <= '0;
    else if (eop_xfer) frame_count_q <= frame_count_q + 1'b1;
  end

  // Read-back multiplexer
  always_comb begin
    rd_mux = 32'h0;
    case (address)
      ADDR_CTRL:    rd_mux = {30'b0, single_shot_q, enable_q};
      ADDR_PATTERN: rd_mux = {30'b0, pattern_sel_q};
      ADDR_COLOR:   rd_mux = {16'b0, solid_color_q};
      ADDR_STATUS:  rd_mux = {15'b0, busy, frame_count_q};
      default:      rd_mux = 32'h0;
    endcase
  end

  // Registered read data, one cycle after the read strobe
  always_ff @(posedge clk) begin
    if (!reset)                 readdata_q <= '0;
    else if (chipselect & read) readdata_q <= rd_mux;
  end

  assign readdata = readdata_q;

  pattern_pixel_calc u_pixel_calc (
    .pattern (pattern_lat_q),
    .x       (8'(x_q)),
    .y       (8'(y_q)),
    .bar_idx (bar_idx_q),
    .color   (color_lat_q),
    .pixel   (pixel)
  );

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on an 8x4 frame; expected pixels
// are queued when a frame is armed and popped on every stream transfer.
module tb_video_pattern_gen;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk;
  logic        reset;
  logic        chipselect;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        source_valid_out;
  logic        source_ready_in;
  logic [15:0] source_data_out;
  logic        source_startofpacket_out;
  logic        source_endofpacket_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;

  logic [17:0] sb[$];
  logic [15:0] bars [0:7] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  logic        stall_prev = 1'b0;
  logic [15:0] prev_data;
  logic        prev_sop, prev_eop;

  video_pattern_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .chipselect               (chipselect),
    .address                  (address),
    .write                    (write),
    .writedata                (writedata),
    .read                     (read),
    .readdata                 (readdata),
    .source_valid_out         (source_valid_out),
    .source_ready_in          (source_ready_in),
    .source_data_out          (source_data_out),
    .source_startofpacket_out (source_startofpacket_out),
    .source_endofpacket_out   (source_endofpacket_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_px(input logic [1:0] pat, input logic [15:0] col,
                                           input int x, input int y);
    logic [15:0] xv, yv;
    xv = 16'(x);
    yv = 16'(y);
    case (pat)
      2'd0:    return col;
      2'd1:    return bars[x / (W / 8)];
      2'd2:    return {xv[7:3], yv[7:2], ~xv[7:3]};
      default: return (xv[4] ^ yv[4]) ? col : 16'h0000;
    endcase
  endfunction

  task automatic push_frame(input logic [1:0] pat, input logic [15:0] col);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back({(x == 0 && y == 0), (x == W-1 && y == H-1), model_px(pat, col, x, y)});
  endtask

  // Stream monitor: transfer checks against the scoreboard and stall-hold checks
  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev) begin
        check("hold_valid", {31'b0, source_valid_out}, 32'd1);
        check("hold_data", {16'b0, source_data_out}, {16'b0, prev_data});
        check("hold_sop", {31'b0, source_startofpacket_out}, {31'b0, prev_sop});
        check("hold_eop", {31'b0, source_endofpacket_out}, {31'b0, prev_eop});
      end
      if (source_valid_out && source_ready_in) begin
        logic [17:0] e;
        check("xfer_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("px_data", {16'b0, source_data_out}, {16'b0, e[15:0]});
          check("px_sop", {31'b0, source_startofpacket_out}, {31'b0, e[17]});
          check("px_eop", {31'b0, source_endofpacket_out}, {31'b0, e[16]});
        end
        xfer_cnt++;
      end
      stall_prev = source_valid_out && !source_ready_in;
      prev_data  = source_data_out;
      prev_sop   = source_startofpacket_out;
      prev_eop   = source_endofpacket_out;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    tick(); tick();
    reset = 1'b1;
    sb.delete();
    xfer_cnt = 0;
  endtask

  task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_xfers(input string tag, input int n);
    int i;
    i = 0;
    while (xfer_cnt < n && i < 500) begin tick(); i++; end
    check(tag, {31'b0, xfer_cnt >= n}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((sb.size() != 0 || source_valid_out) && i < 1000) begin tick(); i++; end
    check(tag, {31'b0, (sb.size() == 0) && !source_valid_out}, 32'd1);
    tick(); tick(); tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  rdy_pat;
    reset = 1'b0; chipselect = 1'b0; address = 2'd0; write = 1'b0;
    writedata = 32'h0; read = 1'b0; source_ready_in = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", {31'b0, source_valid_out}, 32'd0);
    check("rst_data", {16'b0, source_data_out}, 32'd0);
    check("rst_sop", {31'b0, source_startofpacket_out}, 32'd0);
    check("rst_eop", {31'b0, source_endofpacket_out}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    for (int a = 0; a < 4; a++) begin
      mm_read(2'(a), rd);
      check("rst_reg", rd, 32'd0);
    end
    mm_write(2'd3, 32'hFFFF_FFFF);
    mm_read(2'd3, rd);
    check("reg3_ro", rd, 32'd0);
    mm_write(2'd0, 32'hFFFF_FFFC);
    mm_read(2'd0, rd);
    check("reg0_unused", rd, 32'd0);
    mm_write(2'd2, 32'hDEAD_BEEF);
    mm_read(2'd2, rd);
    check("reg2_rw", rd, 32'h0000_BEEF);

    // Colour bars, continuous ready, enable dropped mid-frame
    do_reset();
    mm_write(2'd1, 32'd1);
    push_frame(2'd1, 16'h0000);
    mm_write(2'd0, 32'd1);
    wait_xfers("bars_start", 5);
    mm_write(2'd0, 32'd0);
    wait_idle("bars_idle");
    check("bars_xfers", xfer_cnt, 32'd32);
    mm_read(2'd3, rd);
    check("bars_status", rd, 32'h0000_0001);

    // Single-shot solid frame
    do_reset();
    mm_write(2'd2, 32'h1234);
    mm_write(2'd1, 32'd0);
    push_frame(2'd0, 16'h1234);
    mm_write(2'd0, 32'd3);
    wait_idle("solid_idle");
    check("solid_xfers", xfer_cnt, 32'd32);
    check("solid_valid", {31'b0, source_valid_out}, 32'd0);
    mm_read(2'd0, rd);
    check("solid_reg0", rd, 32'h0);
    mm_read(2'd3, rd);
    check("solid_status", rd, 32'h0000_0001);

    // Backpressure: ready 1,0,0,1 repeating
    do_reset();
    rdy_pat = 4'b1001;
    mm_write(2'd2, 32'h5A5A);
    mm_write(2'd1, 32'd1);
    push_frame(2'd1, 16'h5A5A);
    mm_write(2'd0, 32'd3);
    for (int i = 0; i < 400; i++) begin
      source_ready_in = rdy_pat[i % 4];
      tick();
      if (sb.size() == 0 && !source_valid_out) break;
    end
    source_ready_in = 1'b1;
    wait_idle("bp_idle");
    check("bp_xfers", xfer_cnt, 32'd32);

    // Enable cleared after pixel 10 on a gradient frame
    do_reset();
    mm_write(2'd1, 32'd2);
    push_frame(2'd2, 16'h0000);
    mm_write(2'd0, 32'd1);
    wait_xfers("grad_start", 11);
    mm_write(2'd0, 32'd0);
    wait_idle("grad_idle");
    check("grad_xfers", xfer_cnt, 32'd32);
    mm_read(2'd3, rd);
    check("grad_busy", {31'b0, rd[16]}, 32'd0);

    // Reset at pixel 5 aborts the frame; restart begins at (0,0)
    do_reset();
    mm_write(2'd2, 32'hABCD);
    push_frame(2'd0, 16'hABCD);
    mm_write(2'd0, 32'd1);
    wait_xfers("abort_start", 5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_valid", {31'b0, source_valid_out}, 32'd0);
    check("abort_eop", {31'b0, source_endofpacket_out}, 32'd0);
    sb.delete();
    xfer_cnt = 0;
    mm_read(2'd3, rd);
    check("abort_status", rd, 32'h0);
    mm_write(2'd2, 32'hABCD);
    push_frame(2'd0, 16'hABCD);
    mm_write(2'd0, 32'd3);
    wait_idle("restart_idle");
    check("restart_xfers", xfer_cnt, 32'd32);

    // Pattern change mid-frame only affects the following frame
    do_reset();
    mm_write(2'd2, 32'hFFFF);
    mm_write(2'd1, 32'd0);
    push_frame(2'd0, 16'hFFFF);
    push_frame(2'd3, 16'hFFFF);
    mm_write(2'd0, 32'd1);
    wait_xfers("mid_start", 10);
    mm_write(2'd1, 32'd3);
    wait_xfers("mid_second", 33);
    mm_write(2'd0, 32'd0);
    wait_idle("mid_idle");
    check("mid_xfers", xfer_cnt, 32'd64);
    mm_read(2'd3, rd);
    check("mid_status", rd, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 320, pixels per line (multiple of 8, min 8).
REQ-002 SHALL have parameter HEIGHT, default 240, lines per frame (min 2).
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port chipselect  in  1  Avalon-MM slave select.
REQ-006 SHALL have port address  in  2  register index.
REQ-007 SHALL have ports write  in  1, writedata  in  32, read  in  1, readdata  out  32: Avalon-MM access.
REQ-008 SHALL have ports source_valid_out  out  1, source_ready_in  in  1, source_data_out  out  16 (RGB565): Avalon-ST source, ready latency 0.
REQ-009 SHALL have ports source_startofpacket_out  out  1, source_endofpacket_out  out  1: frame delimiters.

Function
REQ-010 Register map: reg0 = enable[0], single_shot[1]; reg1 = pattern_sel[1:0]; reg2 = solid_color[15:0]; reg3 (read-only) = busy[16], frame_count[15:0]; writes to reg3 ignored.
REQ-011 Read: readdata registered, valid the cycle after chipselect&read; unused bits read 0.
REQ-012 FSM states: IDLE, STREAM, DONE.
REQ-013 IDLE -> STREAM when enable=1; pattern_sel and solid_color latched on that transition and held for the whole frame.
REQ-014 STREAM: pixel counters x (0..WIDTH-1), y (0..HEIGHT-1) emitted raster order; source_valid_out=1.
REQ-015 Transfer occurs only on a cycle with source_valid_out & source_ready_in; counters advance only on transfer.
REQ-016 With valid=1 and ready=0, data, sop, eop SHALL hold unchanged.
REQ-017 source_startofpacket_out=1 only for pixel (0,0); source_endofpacket_out=1 only for pixel (WIDTH-1,HEIGHT-1).
REQ-018 Transfer of eop pixel: frame_count increments (wraps 0xFFFF->0); state -> DONE.
REQ-019 DONE (one cycle, valid=0): single_shot=1 clears enable and -> IDLE; else enable=1 -> STREAM (relatch config, x=y=0); else -> IDLE.
REQ-020 Clearing enable mid-frame SHALL NOT truncate the frame; current frame completes, then IDLE.
REQ-021 pattern 0 solid: data=solid_color.
REQ-022 pattern 1 bars: 8 vertical bars of WIDTH/8 pixels, colours FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000 left to right; bar index by counter, no divider.
REQ-023 pattern 2 gradient: R=x[7:3], G=y[7:2], B=~x[7:3].
REQ-024 pattern 3 checker: (x[4]^y[4]) ? solid_color : 0000.
REQ-025 busy = (state != IDLE).
REQ-026 Simultaneous MM write of pattern_sel during STREAM SHALL affect only the next frame.

Reset
REQ-027 On reset=0 at a clock edge: state IDLE, x=y=0, all registers 0, frame_count 0, readdata 0, source_valid_out/sop/eop 0, source_data_out 0.
REQ-028 Reset mid-frame SHALL abort immediately; no eop emitted for the aborted frame.

Structure
REQ-029 Shared package SHALL hold FSM state encoding, pattern_sel codes, register address constants and the 8 bar colour constants.
REQ-030 One sub-module, pattern_pixel_calc (combinational: pattern, x, y, bar index, colour -> pixel), SHALL be used; FSM, counters and MM registers stay in top.

Verification (WIDTH=8, HEIGHT=4)
REQ-031 reg1=1, reg0=1, ready=1 always -> 32 transfers: line 0 = FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000; sop on 1st, eop on 32nd; frame_count=1.
REQ-032 reg2=0x1234, reg1=0, reg0=3 -> exactly one frame of 0x1234, then valid=0, reg0 reads 0x0, reg3 reads 0x00000001.
REQ-033 ready toggled 1,0,0,1 repeatedly -> data/sop/eop stable while ready=0; 32 transfers total, no pixel lost or duplicated.
REQ-034 enable cleared after pixel 10 -> remaining 22 pixels still sent with eop, then IDLE, busy=0.
REQ-035 reset=0 at pixel 5 -> next cycle valid=0, reg3=0; re-enable restarts with sop at pixel (0,0).
REQ-036 reg1 written 0->3 mid-frame (solid 0xFFFF) -> current frame all 0xFFFF; next frame checker, pixel(0,0)=0000.
